// File: rtl/fft_cfg_pkg.sv
// Shared types and width helpers for the FFT configuration stream.
// Field widths and the packed word width are derived here so packer and top agree.
package fft_cfg_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    function automatic int pad8(input int w);
        return ((w + 7) / 8) * 8;
    endfunction

    // Absent fields still need a 1-bit port.
    function automatic int fld_w(input int w);
        return (w > 0) ? w : 1;
    endfunction

    function automatic int cfg_width(input int channels, input int scale_w,
                                     input int nfft_w, input int cp_w);
        return pad8(nfft_w) + pad8(cp_w) + pad8(channels + channels * scale_w);
    endfunction

endpackage

// File: rtl/fft_cfg_pack.sv
// Combinational packer: NFFT, CP_LEN and the direction/schedule group,
// each byte-aligned, LSB first. Absent fields occupy no bits.
module fft_cfg_pack
    import fft_cfg_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int SCALE_W  = 4,
    parameter int NFFT_W   = 0,
    parameter int CP_W     = 0
) (
    input  logic [fld_w(NFFT_W)-1:0]                         nfft,
    input  logic [fld_w(CP_W)-1:0]                           cp_len,
    input  logic [CHANNELS-1:0]                              fwd_inv,
    input  logic [CHANNELS*SCALE_W-1:0]                      scale_sch,
    output logic [cfg_width(CHANNELS,SCALE_W,NFFT_W,CP_W)-1:0] cfg
);

    localparam int NF   = fld_w(NFFT_W);
    localparam int CF   = fld_w(CP_W);
    localparam int NOFF = 0;
    localparam int COFF = pad8(NFFT_W);
    localparam int GOFF = COFF + pad8(CP_W);

    always_comb begin
        cfg = '0;
        if (NFFT_W > 0) begin
            cfg[NOFF +: NF] = nfft;
        end
        if (CP_W > 0) begin
            cfg[COFF +: CF] = cp_len;
        end
        cfg[GOFF +: CHANNELS]                      = fwd_inv;
        cfg[GOFF + CHANNELS +: CHANNELS * SCALE_W] = scale_sch;
    end

endmodule

// File: rtl/fft_config_stream.sv
// Sends the packed FFT configuration word over AXI4-Stream; a one-deep shadow
// keeps a commit that arrives mid-transfer, newer commits overwrite it.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no word outstanding, tvalid low, waiting for commit
// ST_SEND | tvalid high, tdata held until tready; shadow may be pending
module fft_config_stream
    import fft_cfg_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int SCALE_W  = 4,
    parameter int NFFT_W   = 0,
    parameter int CP_W     = 0,
    parameter int CNT_W    = 16
) (
    input  logic                                               clk,
    input  logic                                               resetn,
    input  logic [fld_w(NFFT_W)-1:0]                           nfft,
    input  logic [fld_w(CP_W)-1:0]                             cp_len,
    input  logic [CHANNELS-1:0]                                fwd_inv,
    input  logic [CHANNELS*SCALE_W-1:0]                        scale_sch,
    input  logic                                               commit,
    output logic                                               tvalid,
    input  logic                                               tready,
    output logic                                               tlast,
    output logic [cfg_width(CHANNELS,SCALE_W,NFFT_W,CP_W)-1:0] tdata,
    output logic                                               busy,
    output logic                                               coalesced,
    output logic [CNT_W-1:0]                                   sent_count
);

    localparam int CFG_W = cfg_width(CHANNELS, SCALE_W, NFFT_W, CP_W);

    state_t             state_q, state_d;
    logic [CFG_W-1:0]   live_word;
    logic [CFG_W-1:0]   tdata_q, tdata_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic               busy_q, busy_d;
    logic               coal_q, coal_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               handshake;

    fft_cfg_pack #(
        .CHANNELS (CHANNELS),
        .SCALE_W  (SCALE_W),
        .NFFT_W   (NFFT_W),
        .CP_W     (CP_W)
    ) u_pack (
        .nfft      (nfft),
        .cp_len    (cp_len),
        .fwd_inv   (fwd_inv),
        .scale_sch (scale_sch),
        .cfg       (live_word)
    );

    assign handshake = (state_q == ST_SEND) && tready;

    always_comb begin
        state_d   = state_q;
        tdata_d   = tdata_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        coal_d    = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    tdata_d = live_word;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A fresh commit beats the older shadow, which is then dropped.
                    if (commit) begin
                        tdata_d = live_word;
                        if (pending_q) begin
                            pending_d = 1'b0;
                            coal_d    = 1'b1;
                        end
                    end else if (pending_q) begin
                        tdata_d   = shadow_q;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (commit) begin
                    shadow_d  = live_word;
                    pending_d = 1'b1;
                    coal_d    = pending_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SEND) || pending_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            tdata_q   <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            coal_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            tdata_q   <= tdata_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            coal_q    <= coal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign tvalid     = (state_q == ST_SEND);
    assign tlast      = tvalid;
    assign tdata      = tdata_q;
    assign busy       = busy_q;
    assign coalesced  = coal_q;
    assign sent_count = cnt_q;

endmodule
